odu_chan_scheduler: RTL and testbench
=====================================

ODU_CHAN_SCHEDULER -- requirements
Module: odu_chan_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of ODU channels; SHALL equal 2**CHW.
REQ-002 Parameter CHW, default 2: channel-ID width.
REQ-003 clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 slot_valid  input  1  one timeslot of line bandwidth is present this cycle.
REQ-006 slot_chid  input  CHW  channel owning the current timeslot; valid when slot_valid=1.
REQ-007 cfg_ch_en  input  NUM_CH  per-channel enable.
REQ-008 cfg_type  input  NUM_CH  per-channel type; 0 = ODU0 (X=19, Y=2086), 1 = ODU2 (X=76, Y=1043).
REQ-009 gen_valid  output  1  scheduler offers one data-generation grant.
REQ-010 gen_chid  output  CHW  channel of the offered grant.
REQ-011 gen_ready  input  1  data generator accepts the offer.
REQ-012 stat_sel  input  CHW  selects channel for the statistics read.
REQ-013 stat_cnt  output  16  grant count of channel stat_sel.

Function
REQ-014 Each channel SHALL hold a 32-bit unsigned credit accumulator acc[ch].
REQ-015 On slot_valid=1 with cfg_ch_en[slot_chid]=1, acc[slot_chid] SHALL increase by X of cfg_type[slot_chid], saturating at 32'hFFFF_FFFF.
REQ-016 Channel ch SHALL be eligible when cfg_ch_en[ch]=1 and acc[ch] >= Y of cfg_type[ch].
REQ-017 FSM states IDLE, OFFER; IDLE: gen_valid=0; if any channel eligible, select first eligible at or after rr_ptr (wrapping NUM_CH-1 to 0), load gen_chid, go OFFER.
REQ-018 OFFER: gen_valid=1; gen_valid and gen_chid SHALL stay constant until gen_ready=1.
REQ-019 On gen_valid=1 and gen_ready=1: acc[gen_chid] -= Y (no change if it is below Y), rr_ptr = gen_chid+1 mod NUM_CH, go IDLE.
REQ-020 Minimum spacing between accepted grants SHALL be 2 cycles (one IDLE bubble).
REQ-021 gen_valid SHALL assert at earliest the cycle after the edge at which acc crosses Y.
REQ-022 Same-cycle slot add and grant subtract on one channel SHALL yield acc+X-Y.
REQ-023 cfg_ch_en[ch]=0 SHALL clear acc[ch] to 0 next edge; an offer already in OFFER SHALL be held until accepted.
REQ-024 cfg_type change SHALL apply to the next add/compare without clearing acc.
REQ-025 slot_valid with disabled slot_chid SHALL be ignored.

Reset
REQ-026 On rst=1: state IDLE, all acc=0, rr_ptr=0, gen_valid=0, gen_chid=0, stat counters=0, stat_cnt=0.
REQ-027 Reset asserted during OFFER SHALL drop gen_valid immediately (asynchronously); the pending grant SHALL be lost.

Configuration
REQ-028 Macro ODU_SCHED_STATS_EN defined: per-channel 16-bit wrapping grant counters increment on each accepted grant; stat_cnt registered, showing count of stat_sel one cycle after selection.
REQ-029 ODU_SCHED_STATS_EN undefined: no counters; stat_cnt SHALL be constant 0; port list unchanged.

Verification
REQ-030 Ch0 type0 enabled, slots only to ch0, gen_ready=1: no gen_valid after 109 slots (acc=2071); gen_valid, gen_chid=0 after slot 110 (acc=2090); after accept acc=4.
REQ-031 Ch1 type1, slots to ch1: first grant after slot 14 (acc=1064), acc=21 after accept.
REQ-032 Ch0..ch3 all eligible, gen_ready=1: grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-033 Ch2 in OFFER, gen_ready=0 for 5 cycles, cfg_ch_en[2] dropped: gen_valid, gen_chid=2 held stable; on accept acc[2]=0, no underflow.
REQ-034 Slot add to ch0 in the accept cycle with acc=2090: acc becomes 2090+19-2086=23.
REQ-035 With ODU_SCHED_STATS_EN, 3 accepted grants to ch3, stat_sel=3: stat_cnt=3; without the macro stat_cnt=0; rst mid-OFFER: gen_valid=0 same cycle, all acc=0.

Source files
------------

// File: rtl/odu_chan_scheduler.sv
// odu_chan_scheduler: credit-based ODU channel scheduler.
// Each channel earns X credits per owned line timeslot. It may be granted once
// its credit reaches Y. Grants are offered one at a time with a valid/ready
// handshake, and eligible channels are chosen in round-robin order.
// Optional feature macro: ODU_SCHED_STATS_EN adds per-channel 16-bit grant
// counters, which are read through stat_sel/stat_cnt. When the macro is not
// defined, stat_cnt is held at 0.
module odu_chan_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CHW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slot_valid,
  input  logic [CHW-1:0]    slot_chid,
  input  logic [NUM_CH-1:0] cfg_ch_en,
  input  logic [NUM_CH-1:0] cfg_type,
  output logic              gen_valid,
  output logic [CHW-1:0]    gen_chid,
  input  logic              gen_ready,
  input  logic [CHW-1:0]    stat_sel,
  output logic [15:0]       stat_cnt
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_OFFER = 1'b1;

  // Credit earned per timeslot: ODU0 = 19, ODU2 = 76.
  function automatic logic [31:0] x_of(input logic t);
    return t ? 32'd76 : 32'd19;
  endfunction

  // Credit cost of one grant: ODU0 = 2086, ODU2 = 1043.
  function automatic logic [31:0] y_of(input logic t);
    return t ? 32'd1043 : 32'd2086;
  endfunction

  logic                     state_reg;
  logic [CHW-1:0]           rr_ptr_reg;
  logic [CHW-1:0]           gen_chid_reg;
  logic [NUM_CH-1:0][31:0]  acc_reg;
  logic [NUM_CH-1:0][31:0]  acc_next;
  logic [NUM_CH-1:0]        elig;
  logic                     accept;
  logic                     pick_found;
  logic [CHW-1:0]           pick_ch;
  logic [CHW-1:0]           pick_idx;

  assign gen_valid = (state_reg == ST_OFFER);
  assign gen_chid  = gen_chid_reg;
  assign accept    = gen_valid && gen_ready;

  // Per-channel credit arithmetic and eligibility.
  // The add and the subtract are combined in a single 33-bit sum. A
  // simultaneous slot and grant therefore nets to acc+X-Y. Bit 32 of the
  // sum can only be set by an add, so that bit drives saturation.
  // Disabling a channel discards its credit.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
      logic        add_hit;
      logic        sub_hit;
      logic [32:0] sum_w;
      assign add_hit = slot_valid && cfg_ch_en[gi] && (slot_chid == CHW'(gi));
      assign sub_hit = accept && (gen_chid_reg == CHW'(gi)) &&
                       (acc_reg[gi] >= y_of(cfg_type[gi]));
      assign sum_w   = {1'b0, acc_reg[gi]}
                     + (add_hit ? {1'b0, x_of(cfg_type[gi])} : 33'd0)
                     - (sub_hit ? {1'b0, y_of(cfg_type[gi])} : 33'd0);
      assign acc_next[gi] = !cfg_ch_en[gi] ? 32'd0 :
                            (sum_w[32] ? 32'hFFFF_FFFF : sum_w[31:0]);
      assign elig[gi] = cfg_ch_en[gi] && (acc_reg[gi] >= y_of(cfg_type[gi]));
    end
  endgenerate

  // Round-robin pick: the first eligible channel at or after rr_ptr.
  // The loop runs from the largest offset down, so the smallest offset wins.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = rr_ptr_reg;
    pick_idx   = rr_ptr_reg;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      pick_idx = rr_ptr_reg + CHW'(k);
      if (elig[pick_idx]) begin
        pick_found = 1'b1;
        pick_ch    = pick_idx;
      end
    end
  end

  // Credit accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_reg <= '0;
    else     acc_reg <= acc_next;
  end

  // Offer FSM: latch a pick in IDLE, then hold it until it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= '0;
      gen_chid_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_found) begin
            gen_chid_reg <= pick_ch;
            state_reg    <= ST_OFFER;
          end
        end
        default: begin
          if (gen_ready) begin
            rr_ptr_reg <= gen_chid_reg + CHW'(1);
            state_reg  <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef ODU_SCHED_STATS_EN
  logic [NUM_CH-1:0][15:0] cnt_reg;
  logic [15:0]             stat_cnt_reg;

  // Wrapping grant counters, plus a registered readout of the selected counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      stat_cnt_reg <= '0;
    end else begin
      if (accept) cnt_reg[gen_chid_reg] <= cnt_reg[gen_chid_reg] + 16'd1;
      stat_cnt_reg <= cnt_reg[stat_sel];
    end
  end

  assign stat_cnt = stat_cnt_reg;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = 16'd0;
`endif

endmodule

// File: tb/tb_odu_chan_scheduler.sv
// Directed testbench for odu_chan_scheduler. It uses a table-driven
// round-robin sequence plus hand-written multi-cycle corner cases.
module tb_odu_chan_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        slot_valid;
  logic [1:0]  slot_chid;
  logic [3:0]  cfg_ch_en;
  logic [3:0]  cfg_type;
  logic        gen_valid;
  logic [1:0]  gen_chid;
  logic        gen_ready;
  logic [1:0]  stat_sel;
  logic [15:0] stat_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       ready;
    logic       exp_valid;
    logic [1:0] exp_chid;
  } vec_t;

  vec_t tbl [10];

  odu_chan_scheduler #(.NUM_CH(4), .CHW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .slot_valid (slot_valid),
    .slot_chid  (slot_chid),
    .cfg_ch_en  (cfg_ch_en),
    .cfg_type   (cfg_type),
    .gen_valid  (gen_valid),
    .gen_chid   (gen_chid),
    .gen_ready  (gen_ready),
    .stat_sel   (stat_sel),
    .stat_cnt   (stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    slot_valid = 1'b0;
    slot_chid  = 2'd0;
    cfg_ch_en  = 4'b0000;
    cfg_type   = 4'b0000;
    gen_ready  = 1'b0;
    stat_sel   = 2'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic slots(input logic [1:0] ch, input int n);
    slot_valid = 1'b1;
    slot_chid  = ch;
    repeat (n) tick();
    slot_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_stat;
`ifdef ODU_SCHED_STATS_EN
    exp_stat = 16'd3;
`else
    exp_stat = 16'd0;
`endif

    // Round-robin table: each entry is {ready, expected valid, expected chid}.
    tbl[0] = '{1'b1, 1'b1, 2'd0};
    tbl[1] = '{1'b1, 1'b0, 2'd0};
    tbl[2] = '{1'b1, 1'b1, 2'd1};
    tbl[3] = '{1'b1, 1'b0, 2'd0};
    tbl[4] = '{1'b1, 1'b1, 2'd2};
    tbl[5] = '{1'b1, 1'b0, 2'd0};
    tbl[6] = '{1'b1, 1'b1, 2'd3};
    tbl[7] = '{1'b1, 1'b0, 2'd0};
    tbl[8] = '{1'b1, 1'b1, 2'd0};
    tbl[9] = '{1'b0, 1'b0, 2'd0};

    // Reset state.
    do_reset();
    check("rst_gen_valid", 32'(gen_valid), 32'd0);
    check("rst_gen_chid", 32'(gen_chid), 32'd0);
    check("rst_stat_cnt", 32'(stat_cnt), 32'd0);
    check("rst_acc0", dut.acc_reg[0], 32'd0);

    // ODU0 on ch0: 109 slots give no grant, and the 110th slot crosses Y.
    do_reset();
    cfg_ch_en = 4'b0001;
    gen_ready = 1'b1;
    slots(2'd0, 109);
    check("odu0_acc_109", dut.acc_reg[0], 32'd2071);
    check("odu0_valid_109", 32'(gen_valid), 32'd0);
    slots(2'd0, 1);
    check("odu0_acc_110", dut.acc_reg[0], 32'd2090);
    check("odu0_valid_cross_edge", 32'(gen_valid), 32'd0);
    tick();
    check("odu0_valid_offer", 32'(gen_valid), 32'd1);
    check("odu0_chid_offer", 32'(gen_chid), 32'd0);
    tick();
    check("odu0_acc_after", dut.acc_reg[0], 32'd4);
    check("odu0_valid_after", 32'(gen_valid), 32'd0);

    // Same-cycle add and grant on ch0: 2090 + 19 - 2086.
    do_reset();
    cfg_ch_en = 4'b0001;
    gen_ready = 1'b1;
    slots(2'd0, 110);
    tick();
    check("addsub_valid", 32'(gen_valid), 32'd1);
    slots(2'd0, 1);
    check("addsub_acc", dut.acc_reg[0], 32'd23);

    // ODU2 on ch1: the grant comes after 14 slots. Slots to disabled ch0 are ignored.
    do_reset();
    cfg_ch_en = 4'b0010;
    cfg_type  = 4'b0010;
    gen_ready = 1'b1;
    slots(2'd0, 3);
    check("disabled_slot_acc0", dut.acc_reg[0], 32'd0);
    slots(2'd1, 13);
    check("odu2_acc_13", dut.acc_reg[1], 32'd988);
    slots(2'd1, 1);
    check("odu2_acc_14", dut.acc_reg[1], 32'd1064);
    tick();
    check("odu2_valid", 32'(gen_valid), 32'd1);
    check("odu2_chid", 32'(gen_chid), 32'd1);
    tick();
    check("odu2_acc_after", dut.acc_reg[1], 32'd21);

    // A type change keeps the credit and applies to the next add.
    do_reset();
    cfg_ch_en = 4'b0001;
    slots(2'd0, 3);
    check("type_acc_before", dut.acc_reg[0], 32'd57);
    cfg_type = 4'b0001;
    slots(2'd0, 1);
    check("type_acc_after", dut.acc_reg[0], 32'd133);

    // All four channels eligible: grants go 0,1,2,3,0 with idle bubbles.
    do_reset();
    cfg_ch_en = 4'b1111;
    cfg_type  = 4'b1111;
    for (int i = 0; i < 120; i++) begin
      slot_valid = 1'b1;
      slot_chid  = 2'(i % 4);
      tick();
    end
    slot_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      gen_ready = tbl[i].ready;
      check($sformatf("rr_valid_%0d", i), 32'(gen_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid)
        check($sformatf("rr_chid_%0d", i), 32'(gen_chid), 32'(tbl[i].exp_chid));
      tick();
    end
    check("rr_acc0", dut.acc_reg[0], 32'd194);
    check("rr_acc3", dut.acc_reg[3], 32'd1237);

    // Offer on ch2 is held while ready stays low. Disabling ch2 clears its credit.
    do_reset();
    cfg_ch_en = 4'b0100;
    cfg_type  = 4'b0100;
    slots(2'd2, 14);
    tick();
    cfg_ch_en = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_valid_%0d", i), 32'(gen_valid), 32'd1);
      check($sformatf("hold_chid_%0d", i), 32'(gen_chid), 32'd2);
      tick();
    end
    check("hold_acc_cleared", dut.acc_reg[2], 32'd0);
    gen_ready = 1'b1;
    tick();
    check("hold_acc_after", dut.acc_reg[2], 32'd0);
    check("hold_valid_after", 32'(gen_valid), 32'd0);

    // Three grants to ch3, then a statistics read.
    do_reset();
    cfg_ch_en = 4'b1000;
    cfg_type  = 4'b1000;
    stat_sel  = 2'd3;
    slots(2'd3, 45);
    gen_ready = 1'b1;
    repeat (8) tick();
    check("stat_acc3", dut.acc_reg[3], 32'd291);
    check("stat_valid_idle", 32'(gen_valid), 32'd0);
    check("stat_cnt_ch3", 32'(stat_cnt), 32'(exp_stat));

    // Reset in the middle of OFFER drops gen_valid without waiting for a clock.
    do_reset();
    cfg_ch_en = 4'b0010;
    cfg_type  = 4'b0010;
    slots(2'd1, 14);
    tick();
    check("arst_valid_before", 32'(gen_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(gen_valid), 32'd0);
    check("arst_acc1", dut.acc_reg[1], 32'd0);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
